// File: rtl/wb_arbiter_if.sv
// Bundle of the two producer handshakes and the register-file write port.
// The arbiter takes the slave view; whoever drives the producers takes the master view.
interface wb_arbiter_if #(
    parameter int XLEN           = 32,
    parameter int XREG_ADDRWIDTH = 5
);
    logic                      i_alu_valid;
    logic                      o_alu_ready;
    logic [XREG_ADDRWIDTH-1:0] i_alu_rd;
    logic [XLEN-1:0]           i_alu_data;

    logic                      i_lsu_valid;
    logic                      o_lsu_ready;
    logic [XREG_ADDRWIDTH-1:0] i_lsu_rd;
    logic [2:0]                i_lsu_funct3;
    logic [1:0]                i_lsu_offset;
    logic [XLEN-1:0]           i_lsu_data;

    logic                      o_write_flag;
    logic [XREG_ADDRWIDTH-1:0] o_write_addr;
    logic [XLEN-1:0]           o_write_data;
    logic                      o_idle;

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_funct3, i_lsu_offset, i_lsu_data,
        output o_alu_ready, o_lsu_ready,
        output o_write_flag, o_write_addr, o_write_data, o_idle
    );

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_funct3, i_lsu_offset, i_lsu_data,
        input  o_alu_ready, o_lsu_ready,
        input  o_write_flag, o_write_addr, o_write_data, o_idle
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers ALU and LSU results in small FIFOs and retires one
// per cycle by round-robin into a registered register-file write port.
module wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int XREG_ADDRWIDTH = 5,
    parameter int FIFO_DEPTH     = 2
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus_io
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [XREG_ADDRWIDTH-1:0] rd;
        logic [XLEN-1:0]           data;
    } aluEntry_t;

    typedef struct packed {
        logic [XREG_ADDRWIDTH-1:0] rd;
        logic [2:0]                funct3;
        logic [1:0]                offset;
        logic [XLEN-1:0]           data;
    } lsuEntry_t;

    typedef enum logic {GRANT_ALU, GRANT_LSU} grant_e;

    aluEntry_t                 aluMem_q [FIFO_DEPTH];
    lsuEntry_t                 lsuMem_q [FIFO_DEPTH];
    logic [PW-1:0]             aluWptr_q, aluRptr_q, lsuWptr_q, lsuRptr_q;
    logic [CW-1:0]             aluCount_q, aluCount_d, lsuCount_q, lsuCount_d;
    grant_e                    lastGrant_q;
    logic                      writeFlag_q;
    logic [XREG_ADDRWIDTH-1:0] writeAddr_q;
    logic [XLEN-1:0]           writeData_q;

    logic      aluPush, lsuPush, aluPop, lsuPop, aluNotEmpty, lsuNotEmpty;
    aluEntry_t aluHead;
    lsuEntry_t lsuHead;

    function automatic logic [XLEN-1:0] extendLoad(input logic [2:0] funct3,
                                                   input logic [1:0] offset,
                                                   input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    // Ready depends only on occupancy, so a full FIFO never accepts even while popping.
    always_comb begin
        aluNotEmpty = (aluCount_q != '0);
        lsuNotEmpty = (lsuCount_q != '0);
        aluPush     = bus_io.i_alu_valid && (aluCount_q != FULL);
        lsuPush     = bus_io.i_lsu_valid && (lsuCount_q != FULL);
        aluPop      = aluNotEmpty && (!lsuNotEmpty || (lastGrant_q == GRANT_LSU));
        lsuPop      = lsuNotEmpty && !aluPop;
        aluCount_d  = aluCount_q + CW'(aluPush) - CW'(aluPop);
        lsuCount_d  = lsuCount_q + CW'(lsuPush) - CW'(lsuPop);
        aluHead     = aluMem_q[aluRptr_q];
        lsuHead     = lsuMem_q[lsuRptr_q];
    end

    always_ff @(posedge clk) begin
        if (aluPush) aluMem_q[aluWptr_q] <= '{rd: bus_io.i_alu_rd, data: bus_io.i_alu_data};
        if (lsuPush) lsuMem_q[lsuWptr_q] <= '{rd: bus_io.i_lsu_rd, funct3: bus_io.i_lsu_funct3,
                                              offset: bus_io.i_lsu_offset, data: bus_io.i_lsu_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluWptr_q   <= '0;
            aluRptr_q   <= '0;
            lsuWptr_q   <= '0;
            lsuRptr_q   <= '0;
            aluCount_q  <= '0;
            lsuCount_q  <= '0;
            lastGrant_q <= GRANT_LSU;
            writeFlag_q <= 1'b0;
            writeAddr_q <= '0;
            writeData_q <= '0;
        end else begin
            aluCount_q <= aluCount_d;
            lsuCount_q <= lsuCount_d;
            if (aluPush) aluWptr_q <= aluWptr_q + PW'(1);
            if (lsuPush) lsuWptr_q <= lsuWptr_q + PW'(1);
            // rd==0 entries still consume their slot but never assert the write flag.
            if (aluPop) begin
                aluRptr_q   <= aluRptr_q + PW'(1);
                lastGrant_q <= GRANT_ALU;
                writeFlag_q <= (aluHead.rd != '0);
                writeAddr_q <= aluHead.rd;
                writeData_q <= aluHead.data;
            end else if (lsuPop) begin
                lsuRptr_q   <= lsuRptr_q + PW'(1);
                lastGrant_q <= GRANT_LSU;
                writeFlag_q <= (lsuHead.rd != '0);
                writeAddr_q <= lsuHead.rd;
                writeData_q <= extendLoad(lsuHead.funct3, lsuHead.offset, lsuHead.data);
            end else begin
                writeFlag_q <= 1'b0;
            end
        end
    end

    assign bus_io.o_alu_ready  = (aluCount_q != FULL);
    assign bus_io.o_lsu_ready  = (lsuCount_q != FULL);
    assign bus_io.o_write_flag = writeFlag_q;
    assign bus_io.o_write_addr = writeAddr_q;
    assign bus_io.o_write_data = writeData_q;
    assign bus_io.o_idle       = !aluNotEmpty && !lsuNotEmpty && !writeFlag_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model feeds a scoreboard that a
// negedge monitor drains, plus directed checks on the listed corner cases.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    typedef struct {
        logic [AW-1:0] rd;
        logic [31:0]   data;
    } aluItem_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [2:0]    f3;
        logic [1:0]    off;
        logic [31:0]   data;
    } lsuItem_t;

    typedef struct {
        bit            flag;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } expItem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_arbiter_if #(.XLEN(XLEN), .XREG_ADDRWIDTH(AW)) bus ();

    wb_arbiter #(.XLEN(XLEN), .XREG_ADDRWIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    aluItem_t aluQ[$];
    lsuItem_t lsuQ[$];
    expItem_t expQ[$];
    bit       lastWasLsu = 1'b1;
    int       checks = 0;
    int       passed = 0;
    int       acceptedWrites = 0;
    int       dutWrites = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Load extension from byte/half arithmetic on the word value.
    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        int unsigned bv, hv;
        bv = (w >> (8 * off)) & 32'hFF;
        hv = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (bv >= 128) ? 32'(int'(bv) - 256)   : 32'(bv);
            3'd1:    return (hv >= 32768) ? 32'(int'(hv) - 65536) : 32'(hv);
            3'd4:    return 32'(bv);
            3'd5:    return 32'(hv);
            default: return w;
        endcase
    endfunction

    task automatic modelStep();
        expItem_t e;
        bit aluFull, lsuFull, takeAlu, takeLsu;
        aluItem_t a;
        lsuItem_t l;
        aluFull = (aluQ.size() == DEPTH);
        lsuFull = (lsuQ.size() == DEPTH);
        takeAlu = (aluQ.size() > 0) && ((lsuQ.size() == 0) || lastWasLsu);
        takeLsu = !takeAlu && (lsuQ.size() > 0);
        e = '{flag: 1'b0, addr: '0, data: '0};
        if (takeAlu) begin
            a = aluQ.pop_front();
            e = '{flag: (a.rd != 0), addr: a.rd, data: a.data};
            lastWasLsu = 1'b0;
        end else if (takeLsu) begin
            l = lsuQ.pop_front();
            e = '{flag: (l.rd != 0), addr: l.rd, data: refLoad(l.f3, l.off, l.data)};
            lastWasLsu = 1'b1;
        end
        if (bus.i_alu_valid && !aluFull) begin
            aluQ.push_back('{rd: bus.i_alu_rd, data: bus.i_alu_data});
            if (bus.i_alu_rd != 0) acceptedWrites++;
        end
        if (bus.i_lsu_valid && !lsuFull) begin
            lsuQ.push_back('{rd: bus.i_lsu_rd, f3: bus.i_lsu_funct3, off: bus.i_lsu_offset,
                             data: bus.i_lsu_data});
            if (bus.i_lsu_rd != 0) acceptedWrites++;
        end
        expQ.push_back(e);
    endtask

    // Reference model: reset empties everything, otherwise one arbitration step per edge.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                aluQ.delete();
                lsuQ.delete();
                expQ.delete();
                lastWasLsu = 1'b1;
            end else begin
                modelStep();
            end
        end
    end

    // Monitor: compares the DUT against the oldest scoreboard entry every cycle.
    initial begin
        expItem_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("rst_flag", 32'(bus.o_write_flag), 32'd0);
                checkOutput("rst_idle", 32'(bus.o_idle), 32'd1);
            end else begin
                if (bus.o_write_flag) dutWrites++;
                if (expQ.size() > 0) e = expQ.pop_front();
                else e = '{flag: 1'b0, addr: '0, data: '0};
                checkOutput("sb_flag", 32'(bus.o_write_flag), 32'(e.flag));
                if (e.flag) begin
                    checkOutput("sb_addr", 32'(bus.o_write_addr), 32'(e.addr));
                    checkOutput("sb_data", bus.o_write_data, e.data);
                end
                checkOutput("sb_alu_ready", 32'(bus.o_alu_ready), 32'(aluQ.size() != DEPTH));
                checkOutput("sb_lsu_ready", 32'(bus.o_lsu_ready), 32'(lsuQ.size() != DEPTH));
                checkOutput("sb_idle", 32'(bus.o_idle),
                            32'((aluQ.size() == 0) && (lsuQ.size() == 0) && !e.flag));
            end
        end
    end

    task automatic applyStimulus(input bit av, input logic [AW-1:0] ard, input logic [31:0] ad,
                                 input bit lv, input logic [AW-1:0] lrd, input logic [2:0] f3,
                                 input logic [1:0] off, input logic [31:0] ld);
        bus.i_alu_valid  = av;
        bus.i_alu_rd     = ard;
        bus.i_alu_data   = ad;
        bus.i_lsu_valid  = lv;
        bus.i_lsu_rd     = lrd;
        bus.i_lsu_funct3 = f3;
        bus.i_lsu_offset = off;
        bus.i_lsu_data   = ld;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit sawAluFull, sawLsuFull;
        int writesBefore;
        bus.i_alu_valid = 0; bus.i_alu_rd = 0; bus.i_alu_data = 0;
        bus.i_lsu_valid = 0; bus.i_lsu_rd = 0; bus.i_lsu_funct3 = 0;
        bus.i_lsu_offset = 0; bus.i_lsu_data = 0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_flag", 32'(bus.o_write_flag), 32'd0);
        checkOutput("reset_addr", 32'(bus.o_write_addr), 32'd0);
        checkOutput("reset_data", bus.o_write_data, 32'd0);
        checkOutput("reset_idle", 32'(bus.o_idle), 32'd1);
        checkOutput("reset_alu_ready", 32'(bus.o_alu_ready), 32'd1);
        checkOutput("reset_lsu_ready", 32'(bus.o_lsu_ready), 32'd1);

        // Single ALU result latency
        applyStimulus(1, 5, 32'h0000_1234, 0, 0, 0, 0, 0);
        idleCycle();
        checkOutput("alu_lat_flag", 32'(bus.o_write_flag), 32'd1);
        checkOutput("alu_lat_addr", 32'(bus.o_write_addr), 32'd5);
        checkOutput("alu_lat_data", bus.o_write_data, 32'h0000_1234);
        idleCycle();
        checkOutput("alu_lat_flag_off", 32'(bus.o_write_flag), 32'd0);

        // Load extension corners
        applyStimulus(0, 0, 0, 1, 3, 3'b000, 2'd3, 32'h80FF_FFFF);
        idleCycle();
        checkOutput("lb_data", bus.o_write_data, 32'hFFFF_FF80);
        applyStimulus(0, 0, 0, 1, 4, 3'b100, 2'd3, 32'h80FF_FFFF);
        idleCycle();
        checkOutput("lbu_data", bus.o_write_data, 32'h0000_0080);
        applyStimulus(0, 0, 0, 1, 6, 3'b001, 2'd2, 32'h8001_0000);
        idleCycle();
        checkOutput("lh_data", bus.o_write_data, 32'hFFFF_8001);
        checkOutput("lh_addr", 32'(bus.o_write_addr), 32'd6);

        // Both sources contending: strict alternation starting with ALU
        applyStimulus(1, 1, 32'hA0, 1, 2, 3'b010, 0, 32'hB0);
        applyStimulus(1, 3, 32'hA1, 1, 8, 3'b010, 0, 32'hB1);
        checkOutput("rr_a0", bus.o_write_data, 32'hA0);
        idleCycle();
        checkOutput("rr_l0", bus.o_write_data, 32'hB0);
        idleCycle();
        checkOutput("rr_a1", bus.o_write_data, 32'hA1);
        idleCycle();
        checkOutput("rr_l1", bus.o_write_data, 32'hB1);
        checkOutput("rr_l1_flag", 32'(bus.o_write_flag), 32'd1);
        repeat (2) idleCycle();

        // rd=0 consumes a slot without writing
        applyStimulus(1, 0, 32'h99, 0, 0, 0, 0, 0);
        applyStimulus(1, 7, 32'h55, 0, 0, 0, 0, 0);
        checkOutput("rd0_flag", 32'(bus.o_write_flag), 32'd0);
        idleCycle();
        checkOutput("rd7_flag", 32'(bus.o_write_flag), 32'd1);
        checkOutput("rd7_addr", 32'(bus.o_write_addr), 32'd7);
        checkOutput("rd7_data", bus.o_write_data, 32'h55);

        // Saturation: both push every cycle
        sawAluFull = 0;
        sawLsuFull = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
            if (!bus.o_alu_ready) sawAluFull = 1;
            if (!bus.o_lsu_ready) sawLsuFull = 1;
        end
        checkOutput("sat_alu_ready_low", 32'(sawAluFull), 32'd1);
        checkOutput("sat_lsu_ready_low", 32'(sawLsuFull), 32'd1);
        repeat (6) idleCycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
        end
        repeat (8) idleCycle();
        checkOutput("writes_vs_accepted", 32'(dutWrites), 32'(acceptedWrites));

        // Asynchronous reset with entries still buffered
        applyStimulus(1, 9, 32'h11, 1, 10, 3'b010, 0, 32'h22);
        applyStimulus(1, 11, 32'h33, 1, 12, 3'b010, 0, 32'h44);
        bus.i_alu_valid = 0;
        bus.i_lsu_valid = 0;
        writesBefore = dutWrites;
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_flag", 32'(bus.o_write_flag), 32'd0);
        checkOutput("midrst_idle", 32'(bus.o_idle), 32'd1);
        checkOutput("midrst_data", bus.o_write_data, 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (5) idleCycle();
        checkOutput("midrst_no_writes", 32'(dutWrites), 32'(writesBefore));
        checkOutput("midrst_idle_after", 32'(bus.o_idle), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
